// File: rtl/udp_tx_arbiter.sv
// Two-channel round-robin arbiter in front of a single UDP transmitter.
// Define UDP_ARB_TIMEOUT_EN to add a tx_done watchdog in SEND.
//
// state | meaning
// IDLE  | no owner; requests evaluated, bad lengths rejected
// START | one-cycle tx_start_en to the transmitter
// SEND  | payload streamed from the granted channel FIFO
// GAP   | inter-frame idle time, owner still held

module udp_tx_arbiter #(
    parameter int          GAP_CYCLES     = 12,
    parameter logic [47:0] CH0_DES_MAC    = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] CH0_DES_IP     = {8'd192, 8'd168, 8'd1, 8'd102},
    parameter logic [47:0] CH1_DES_MAC    = 48'hff_ff_ff_ff_ff_ff,
    parameter logic [31:0] CH1_DES_IP     = {8'd192, 8'd168, 8'd1, 8'd102},
    parameter logic [15:0] MAX_BYTES      = 16'd1472,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ch0_req,
    input  logic [15:0] ch0_byte_num,
    output logic        ch0_rd_en,
    input  logic [7:0]  ch0_rd_data,
    output logic        ch0_done,
    output logic        ch0_err,
    input  logic        ch1_req,
    input  logic [15:0] ch1_byte_num,
    output logic        ch1_rd_en,
    input  logic [7:0]  ch1_rd_data,
    output logic        ch1_done,
    output logic        ch1_err,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    output logic [47:0] des_mac,
    output logic [31:0] des_ip,
    output logic [7:0]  tx_data,
    input  logic        tx_req,
    input  logic        tx_done,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, START, SEND, GAP} state_t;

    localparam logic [31:0] GAP_LOAD = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;

    state_t      state, next_state;
    logic        last_ch;
    logic        sel_ch;
    logic [15:0] sel_bytes;
    logic        sel_ok;
    logic        any_req;
    logic        timeout_hit;
    logic [31:0] gap_cnt;
`ifdef UDP_ARB_TIMEOUT_EN
    logic [31:0] to_cnt;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        any_req = ch0_req | ch1_req;
        if (ch0_req && ch1_req) sel_ch = ~last_ch;
        else                    sel_ch = ch1_req;
        sel_bytes = sel_ch ? ch1_byte_num : ch0_byte_num;
        sel_ok    = (sel_bytes != 16'd0) && (sel_bytes <= MAX_BYTES);
`ifdef UDP_ARB_TIMEOUT_EN
        timeout_hit = (state == SEND) && (to_cnt == 32'd0);
`else
        timeout_hit = 1'b0;
`endif
        next_state = state;
        case (state)
            IDLE:    if (any_req && sel_ok) next_state = START;
            START:   next_state = SEND;
            SEND:    if (tx_done || timeout_hit) next_state = GAP;
            GAP:     if (gap_cnt == 32'd0) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        tx_start_en = (state == START);
        ch0_rd_en   = (state == SEND) && tx_req && grant[0];
        ch1_rd_en   = (state == SEND) && tx_req && grant[1];
        case (grant)
            2'b01:   tx_data = ch0_rd_data;
            2'b10:   tx_data = ch1_rd_data;
            default: tx_data = 8'h00;
        endcase
    end

    // Frame context is captured once in IDLE and frozen until GAP expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant       <= 2'b00;
            last_ch     <= 1'b1;
            tx_byte_num <= 16'd0;
            des_mac     <= 48'd0;
            des_ip      <= 32'd0;
            gap_cnt     <= 32'd0;
            ch0_done    <= 1'b0;
            ch1_done    <= 1'b0;
            ch0_err     <= 1'b0;
            ch1_err     <= 1'b0;
`ifdef UDP_ARB_TIMEOUT_EN
            to_cnt      <= 32'd0;
`endif
        end else begin
            ch0_done <= 1'b0;
            ch1_done <= 1'b0;
            ch0_err  <= 1'b0;
            ch1_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last_ch <= sel_ch;
                        if (sel_ok) begin
                            grant       <= sel_ch ? 2'b10 : 2'b01;
                            tx_byte_num <= sel_bytes;
                            des_mac     <= sel_ch ? CH1_DES_MAC : CH0_DES_MAC;
                            des_ip      <= sel_ch ? CH1_DES_IP : CH0_DES_IP;
                        end else begin
                            ch0_err <= ~sel_ch;
                            ch1_err <= sel_ch;
                        end
                    end
                end
                START: begin
`ifdef UDP_ARB_TIMEOUT_EN
                    to_cnt <= TIMEOUT_CYCLES - 32'd1;
`endif
                end
                SEND: begin
                    if (tx_done) begin
                        ch0_done <= grant[0];
                        ch1_done <= grant[1];
                        gap_cnt  <= GAP_LOAD;
                    end else if (timeout_hit) begin
                        ch0_err <= grant[0];
                        ch1_err <= grant[1];
                        gap_cnt <= GAP_LOAD;
                    end
`ifdef UDP_ARB_TIMEOUT_EN
                    else to_cnt <= to_cnt - 32'd1;
`endif
                end
                GAP: begin
                    if (gap_cnt == 32'd0) grant <= 2'b00;
                    else                  gap_cnt <= gap_cnt - 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Self-checking bench for udp_tx_arbiter: selection table, frame-level random model,
// and hand sequences for round-robin, reset mid-frame and the tx_done watchdog.
module tb_udp_tx_arbiter;

    localparam int          GAP  = 12;
    localparam logic [15:0] MAXB = 16'd1472;
    localparam logic [47:0] MAC0 = 48'h02_00_00_00_00_a0;
    localparam logic [47:0] MAC1 = 48'h02_00_00_00_00_b1;
    localparam logic [31:0] IP0  = 32'h0a_00_00_01;
    localparam logic [31:0] IP1  = 32'h0a_00_00_02;

    logic        clk, rst;
    logic        ch0_req, ch1_req, ch0_rd_en, ch1_rd_en;
    logic [15:0] ch0_byte_num, ch1_byte_num, tx_byte_num;
    logic [7:0]  ch0_rd_data, ch1_rd_data, tx_data;
    logic        ch0_done, ch1_done, ch0_err, ch1_err;
    logic        tx_start_en, tx_req, tx_done, busy;
    logic [47:0] des_mac;
    logic [31:0] des_ip;
    logic [1:0]  grant;

    udp_tx_arbiter #(
        .GAP_CYCLES(GAP), .CH0_DES_MAC(MAC0), .CH0_DES_IP(IP0),
        .CH1_DES_MAC(MAC1), .CH1_DES_IP(IP1), .MAX_BYTES(MAXB),
        .TIMEOUT_CYCLES(32'd50)
    ) dut (
        .clk(clk), .rst(rst),
        .ch0_req(ch0_req), .ch0_byte_num(ch0_byte_num), .ch0_rd_en(ch0_rd_en),
        .ch0_rd_data(ch0_rd_data), .ch0_done(ch0_done), .ch0_err(ch0_err),
        .ch1_req(ch1_req), .ch1_byte_num(ch1_byte_num), .ch1_rd_en(ch1_rd_en),
        .ch1_rd_data(ch1_rd_data), .ch1_done(ch1_done), .ch1_err(ch1_err),
        .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .des_mac(des_mac),
        .des_ip(des_ip), .tx_data(tx_data), .tx_req(tx_req), .tx_done(tx_done),
        .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit m_last;  // model: channel served last

    typedef struct packed {
        logic        r0, r1;
        logic [15:0] b0, b1;
        logic [1:0]  exp_grant;
        logic        exp_err0, exp_err1, exp_start;
        logic [15:0] exp_byte;
    } sel_vec_t;
    sel_vec_t tbl [11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic clear_inputs;
        ch0_req = 0; ch1_req = 0; ch0_byte_num = 0; ch1_byte_num = 0;
        ch0_rd_data = 0; ch1_rd_data = 0; tx_req = 0; tx_done = 0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        clear_inputs();
        tick(); tick();
        rst = 1'b0;
        m_last = 1'b1;
    endtask

    function automatic bit len_ok(input logic [15:0] b);
        return (b >= 16'd1) && (b <= MAXB);
    endfunction

    function automatic logic [15:0] pick_len();
        case ($urandom_range(0, 5))
            0:       return 16'd0;
            1:       return MAXB;
            2:       return MAXB + 16'd1;
            3:       return 16'($urandom_range(1, 64));
            4:       return 16'($urandom_range(1473, 65535));
            default: return 16'd1;
        endcase
    endfunction

    // One arbitration decision plus the whole frame it causes, predicted at frame level.
    task automatic episode(input bit r0, input bit r1, input logic [15:0] b0,
                           input logic [15:0] b1, input int send_len, input bit wiggle);
        bit ch, ok;
        logic [15:0] nb;
        logic [1:0]  g;
        ch0_req = r0; ch1_req = r1; ch0_byte_num = b0; ch1_byte_num = b1;
        tick();
        if (!r0 && !r1) begin
            check("noreq_busy", busy, 0);
            check("noreq_err", {ch1_err, ch0_err}, 0);
            return;
        end
        ch = (r0 && r1) ? !m_last : r1;
        nb = ch ? b1 : b0;
        ok = len_ok(nb);
        m_last = ch;
        g = ch ? 2'b10 : 2'b01;
        check("sel_err", {ch1_err, ch0_err}, ok ? 2'b00 : g);
        check("sel_start", tx_start_en, ok);
        check("sel_busy", busy, ok);
        check("sel_grant", grant, ok ? g : 2'b00);
        ch0_req = 0; ch1_req = 0;
        if (!ok) begin
            tick();
            check("rej_busy", busy, 0);
            check("rej_start", tx_start_en, 0);
            check("rej_err_once", {ch1_err, ch0_err}, 0);
            return;
        end
        check("sel_bytes", tx_byte_num, nb);
        check("sel_mac", des_mac, ch ? MAC1 : MAC0);
        check("sel_ip", des_ip, ch ? IP1 : IP0);
        tx_done = 1'($urandom_range(0, 1));
        tick();
        tx_done = 0;
        for (int i = 0; i < send_len; i++) begin
            tx_req = 1'($urandom_range(0, 1));
            ch0_rd_data = 8'($urandom);
            ch1_rd_data = 8'($urandom);
            if (wiggle) begin
                ch0_req = 1'($urandom_range(0, 1)); ch1_req = 1'($urandom_range(0, 1));
                ch0_byte_num = 16'($urandom); ch1_byte_num = 16'($urandom);
            end
            if (i == send_len - 1) tx_done = 1;
            #1;
            check("send_rd0", ch0_rd_en, tx_req && !ch);
            check("send_rd1", ch1_rd_en, tx_req && ch);
            check("send_data", tx_data, ch ? ch1_rd_data : ch0_rd_data);
            check("send_nostart", tx_start_en, 0);
            check("send_done", {ch1_done, ch0_done}, 0);
            check("send_grant", grant, g);
            check("send_bytes", tx_byte_num, nb);
            tick();
        end
        tx_done = 0; tx_req = 0;
        check("done_pulse", {ch1_done, ch0_done}, g);
        for (int i = 0; i < GAP; i++) begin
            check("gap_busy", busy, 1);
            check("gap_grant", grant, g);
            check("gap_mac", des_mac, ch ? MAC1 : MAC0);
            if (i > 0) check("gap_done", {ch1_done, ch0_done}, 0);
            if (wiggle) begin
                tx_done = 1'($urandom_range(0, 1));
                ch0_req = 1'($urandom_range(0, 1)); ch1_req = 1'($urandom_range(0, 1));
            end
            tick();
        end
        tx_done = 0; ch0_req = 0; ch1_req = 0;
        check("gapend_busy", busy, 0);
        check("gapend_grant", grant, 0);
        check("gapend_done", {ch1_done, ch0_done}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int idle_cnt, budget;
        logic [1:0] exp_g;

        tbl[0]  = '{1'b1, 1'b0, 16'd10,    16'd0,    2'b01, 1'b0, 1'b0, 1'b1, 16'd10};
        tbl[1]  = '{1'b0, 1'b1, 16'd0,     16'd20,   2'b10, 1'b0, 1'b0, 1'b1, 16'd20};
        tbl[2]  = '{1'b1, 1'b1, 16'd5,     16'd6,    2'b01, 1'b0, 1'b0, 1'b1, 16'd5};
        tbl[3]  = '{1'b0, 1'b1, 16'd0,     16'd0,    2'b00, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 1'b1, 16'd0,     16'd1500, 2'b00, 1'b0, 1'b1, 1'b0, 16'd0};
        tbl[5]  = '{1'b1, 1'b0, 16'd1472,  16'd0,    2'b01, 1'b0, 1'b0, 1'b1, 16'd1472};
        tbl[6]  = '{1'b1, 1'b0, 16'd1473,  16'd0,    2'b00, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{1'b0, 1'b1, 16'd0,     16'd1,    2'b10, 1'b0, 1'b0, 1'b1, 16'd1};
        tbl[8]  = '{1'b0, 1'b0, 16'd3,     16'd3,    2'b00, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[9]  = '{1'b1, 1'b1, 16'd0,     16'd7,    2'b00, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[10] = '{1'b1, 1'b1, 16'd65535, 16'd9,    2'b00, 1'b1, 1'b0, 1'b0, 16'd0};

        // Outputs while reset is held, with live-looking inputs.
        rst = 1'b1;
        clear_inputs();
        ch0_req = 1; ch0_byte_num = 16'd10; tx_req = 1; ch0_rd_data = 8'h55; tx_done = 1;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_start", tx_start_en, 0);
        check("rst_data", tx_data, 0);
        check("rst_rden", {ch1_rd_en, ch0_rd_en}, 0);
        check("rst_pulses", {ch1_done, ch0_done, ch1_err, ch0_err}, 0);
        check("rst_bytes", tx_byte_num, 0);
        check("rst_mac", des_mac, 0);
        check("rst_ip", des_ip, 0);

        // Selection table, each entry from a fresh reset.
        for (int i = 0; i < 11; i++) begin
            do_reset();
            ch0_req = tbl[i].r0; ch1_req = tbl[i].r1;
            ch0_byte_num = tbl[i].b0; ch1_byte_num = tbl[i].b1;
            tick();
            check("tbl_grant", grant, tbl[i].exp_grant);
            check("tbl_err", {ch1_err, ch0_err}, {tbl[i].exp_err1, tbl[i].exp_err0});
            check("tbl_start", tx_start_en, tbl[i].exp_start);
            check("tbl_busy", busy, tbl[i].exp_start);
            check("tbl_bytes", tx_byte_num, tbl[i].exp_byte);
            if (tbl[i].exp_start)
                check("tbl_mac", des_mac, (tbl[i].exp_grant == 2'b10) ? MAC1 : MAC0);
            ch0_req = 0; ch1_req = 0;
        end

        // Single ch0 frame, tx_done after 30 SEND cycles.
        do_reset();
        episode(1'b1, 1'b0, 16'd10, 16'd0, 30, 1'b0);
        // Rejected ch1 lengths.
        episode(1'b0, 1'b1, 16'd0, 16'd0, 1, 1'b0);
        episode(1'b0, 1'b1, 16'd0, 16'd1500, 1, 1'b0);
        // ch1 streaming with tx_req activity.
        episode(1'b0, 1'b1, 16'd0, 16'd20, 10, 1'b0);

        // Both requests held for four frames.
        do_reset();
        ch0_req = 1; ch1_req = 1; ch0_byte_num = 16'd4; ch1_byte_num = 16'd4;
        for (int f = 0; f < 4; f++) begin
            idle_cnt = 0;
            budget = 0;
            do begin
                tick();
                idle_cnt++;
                budget++;
            end while (!tx_start_en && budget < 40);
            check("rr_started", tx_start_en, 1);
            exp_g = (f % 2 == 0) ? 2'b01 : 2'b10;
            check("rr_grant", grant, exp_g);
            if (f > 0) check("rr_gap", idle_cnt >= GAP, 1);
            tick(); tick();
            tx_done = 1;
            tick();
            tx_done = 0;
            check("rr_done", {ch1_done, ch0_done}, exp_g);
        end
        ch0_req = 0; ch1_req = 0;

        // Reset mid-SEND after ch0 was served.
        do_reset();
        ch0_req = 1; ch0_byte_num = 16'd8;
        tick();
        check("rstmid_grant", grant, 2'b01);
        ch0_req = 0;
        tick();
        tx_done = 1;
        rst = 1;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_grant0", grant, 0);
        check("rstmid_bytes", tx_byte_num, 0);
        tick();
        check("rstmid_nodone", {ch1_done, ch0_done, ch1_err, ch0_err}, 0);
        tx_done = 0;
        rst = 0;
        m_last = 1'b1;
        ch0_req = 1; ch1_req = 1; ch0_byte_num = 16'd9; ch1_byte_num = 16'd9;
        tick();
        check("rstmid_ch0_wins", grant, 2'b01);
        ch0_req = 0; ch1_req = 0;

`ifdef UDP_ARB_TIMEOUT_EN
        // Watchdog fires 50 cycles into SEND.
        do_reset();
        ch1_req = 1; ch1_byte_num = 16'd5;
        tick();
        ch1_req = 0;
        tick();
        idle_cnt = 0;
        while (!ch1_err && idle_cnt < 200) begin
            tick();
            idle_cnt++;
        end
        check("to_cycles", idle_cnt, 50);
        check("to_busy_gap", busy, 1);
        check("to_nodone", {ch1_done, ch0_done}, 0);
        repeat (GAP) tick();
        check("to_idle", busy, 0);
        check("to_grant", grant, 0);
`else
        // Without the watchdog SEND waits for tx_done.
        do_reset();
        ch1_req = 1; ch1_byte_num = 16'd5;
        tick();
        ch1_req = 0;
        repeat (200) tick();
        check("nowd_busy", busy, 1);
        check("nowd_grant", grant, 2'b10);
        check("nowd_err", {ch1_err, ch0_err}, 0);
        tx_done = 1;
        tick();
        tx_done = 0;
        check("nowd_done", {ch1_done, ch0_done}, 2'b10);
`endif

        // Randomized frames against the frame-level model.
        do_reset();
        for (int k = 0; k < 40; k++) begin
            episode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    pick_len(), pick_len(), $urandom_range(1, 12), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
